seq_mult_acc: RTL and testbench
===============================

Name: seq_mult_acc

Overview:
- Parametrised sequential multiply-accumulate unit: product = a*b (+ addend when acc_en), computed one multiplier bit per clock by shift-and-add.
- Generalises the single-bit a*b + c_in + s_in cell to WIDTH-bit operands, adding a valid/ready handshake, an optional accumulate mode, overflow reporting and optional early termination.
- Sits in the FP32 datapath as the mantissa multiplier (24-bit with hidden bit) feeding normalisation in the matrix multiplier.

Parameters:
- WIDTH, 24, operand width in bits; product and addend are 2*WIDTH bits.
- EARLY_TERM, 0, when 1, RUN exits as soon as all remaining multiplier bits are zero.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  unit can accept operands
- a  input  WIDTH  multiplicand (unsigned)
- b  input  WIDTH  multiplier (unsigned)
- acc_en  input  1  1: add addend to product; 0: addend ignored
- addend  input  2*WIDTH  accumulate value (unsigned)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- product  output  2*WIDTH  result modulo 2^(2*WIDTH)
- ovf  output  1  carry out of bit 2*WIDTH-1 (only possible when acc_en=1)
- busy  output  1  state is not IDLE

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE; in_ready=1; out_valid=0; product=0; ovf=0; busy=0; internal a_reg, b_reg, count and acc cleared. Reset mid-RUN or mid-DONE aborts the operation and discards the result.
- FSM states:
  - IDLE: in_ready=1. On in_valid at a clock edge, capture a_reg=a, b_reg=b, acc=(acc_en ? addend : 0), extended to 2*WIDTH+1 bits, count=0; go to RUN.
  - RUN: in_ready=0. Each edge:
    - acc += b_reg[0] ? (a_reg << count) : 0, with the adder 2*WIDTH+1 bits wide;
    - b_reg >>= 1; count++.
    - Go to DONE when count==WIDTH-1, or when EARLY_TERM=1 and (b_reg>>1)==0.
  - DONE: out_valid=1; product=acc[2*WIDTH-1:0]; ovf=acc[2*WIDTH]. Both are held stable while out_ready=0. On out_valid&&out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency, capture edge to out_valid high:
  - EARLY_TERM=0: exactly WIDTH edges after the capture edge.
  - EARLY_TERM=1: 1 + index of the highest set bit of b; b=0 gives 1 cycle.
- No back-to-back overlap: a new operand can be accepted only in the cycle after the result handshake, because in_ready rises only on return to IDLE.
- in_valid while in_ready=0 is ignored; operands are not latched.
- acc_en and addend are sampled only at the capture edge.
- Unsigned arithmetic throughout. Without acc_en, the product fits in 2*WIDTH bits and ovf=0.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Package seq_mult_acc_pkg:
  - state enum IDLE/RUN/DONE (2-bit encoding 00/01/10);
  - default WIDTH constant FP32_MANT_W=24;
  - count width function clog2(WIDTH).
- One natural sub-module: shift_add_step, combinational. It takes acc, a_reg, count and b_bit and returns next acc. Its bit-slice is the a&b + c_in + s_in full-adder cell, replicated 2*WIDTH+1 times as a ripple chain.

Test Plan:
- WIDTH=24, EARLY_TERM=0, a=0xFFFFFF, b=0xFFFFFF, acc_en=0 -> product=0xFFFFFE000001, ovf=0, out_valid exactly 24 cycles after capture.
- acc_en=1, a=b=0xFFFFFF, addend=0xFFFFFFFFFFFF -> product=0xFFFFFE000000, ovf=1.
- EARLY_TERM=1, a=0x800000, b=0x000001 -> product=0x000000800000 after 1 cycle. With b=0x000000 -> product=0, latency 1 cycle.
- Backpressure: complete a=3, b=5; hold out_ready=0 for 5 cycles while pulsing in_valid with other operands.
  - product=15 held stable; in_ready=0 throughout; the pulsed operands are not accepted.
  - After the out_ready handshake, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 at count=10.
  - Immediately (asynchronously): out_valid=0, product=0, busy=0, in_ready=1.
  - A subsequent a=2, b=7 returns 14.
- Exhaustive WIDTH=4 sweep, all a, b, acc_en, and addend in {0, 0xFF, random} -> product/ovf match (a*b+addend) mod 256 and its carry bit.

Source files
------------

// File: rtl/seq_mult_acc_pkg.sv
// Shared types and constants for the sequential multiply-accumulate unit.
package seq_mult_acc_pkg;

    // Mantissa width of an FP32 operand including the hidden bit.
    localparam int FP32_MANT_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of the bit counter; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (clog2(width) < 1) ? 1 : clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_acc_if.sv
// Operand/result handshake bundle for seq_mult_acc.
interface seq_mult_acc_if
    import seq_mult_acc_pkg::*;
#(
    parameter int WIDTH = FP32_MANT_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 acc_en;
    logic [2*WIDTH-1:0]   addend;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 ovf;
    logic                 busy;

    // Producer/consumer side driving operands and taking results.
    modport master (
        output in_valid, a, b, acc_en, addend, out_ready,
        input  in_ready, out_valid, product, ovf, busy
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, a, b, acc_en, addend, out_ready,
        output in_ready, out_valid, product, ovf, busy
    );
endinterface

// File: rtl/seq_mult_acc_shift_add_step.sv
// One shift-and-add iteration: acc + (b_bit ? a << count : 0), built as a
// ripple chain of a&b + c_in + s_in full-adder cells.
module shift_add_step
    import seq_mult_acc_pkg::*;
#(
    parameter int WIDTH = FP32_MANT_W,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              b_bit_i,
    output logic [2*WIDTH:0]  acc_o
);
    localparam int ACC_W = 2 * WIDTH + 1;

    logic [ACC_W-1:0] a_shift;

    assign a_shift = {{(WIDTH + 1){1'b0}}, a_i} << count_i;

    // Ripple the partial-product bit through one full-adder cell per bit.
    always_comb begin : ripple
        logic carry;
        logic pp;
        // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
        carry = 1'b0;
        pp    = 1'b0;
        acc_o = '0;
        for (int i = 0; i < ACC_W; i++) begin
            pp       = a_shift[i] & b_bit_i;
            acc_o[i] = pp ^ acc_i[i] ^ carry;
            carry    = (pp & acc_i[i]) | (pp & carry) | (acc_i[i] & carry);
        end
    end

endmodule

// File: rtl/seq_mult_acc.sv
// Sequential unsigned multiply-accumulate: one multiplier bit per clock,
// valid/ready on both sides, carry-out reported as ovf.
module seq_mult_acc
    import seq_mult_acc_pkg::*;
#(
    parameter int WIDTH      = FP32_MANT_W,
    parameter int EARLY_TERM = 0
) (
    input logic           clk,
    input logic           rst_n,
    seq_mult_acc_if.slave bus
);
    localparam int ACC_W = 2 * WIDTH + 1;
    localparam int CNT_W = cnt_w(WIDTH);

    state_e              state_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [CNT_W-1:0]    count_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [2*WIDTH-1:0]  product_q;
    logic                ovf_q;
    logic                last_step_d;

    shift_add_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .acc_i   (acc_q),
        .a_i     (a_q),
        .count_i (count_q),
        .b_bit_i (b_q[0]),
        .acc_o   (acc_d)
    );

    // Final iteration: all multiplier bits consumed, or (optionally) none left set.
    assign last_step_d = (count_q == CNT_W'(WIDTH - 1)) ||
                         ((EARLY_TERM != 0) && ((b_q >> 1) == '0));

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= bus.acc_en ? {1'b0, bus.addend} : '0;
                        count_q    <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + CNT_W'(1);
                    if (last_step_d) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        product_q   <= acc_d[2*WIDTH-1:0];
                        ovf_q       <= acc_d[2*WIDTH];
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_mult_acc.sv
// Self-checking bench: three instances (24-bit, 24-bit early-terminate,
// 4-bit) driven from one shared stimulus path, checked against a plain
// arithmetic reference model.
module tb_seq_mult_acc;
    import seq_mult_acc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int          sel;
    logic        in_valid_t;
    logic        acc_en_t;
    logic        out_ready_t;
    logic [23:0] a_t;
    logic [23:0] b_t;
    logic [47:0] addend_t;

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [47:0] obs_product;
    logic        obs_ovf;
    logic        obs_busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult_acc_if #(.WIDTH(24)) bus0 ();
    seq_mult_acc_if #(.WIDTH(24)) bus1 ();
    seq_mult_acc_if #(.WIDTH(4))  bus2 ();

    assign bus0.in_valid  = in_valid_t && (sel == 0);
    assign bus0.a         = a_t;
    assign bus0.b         = b_t;
    assign bus0.acc_en    = acc_en_t;
    assign bus0.addend    = addend_t;
    assign bus0.out_ready = out_ready_t && (sel == 0);

    assign bus1.in_valid  = in_valid_t && (sel == 1);
    assign bus1.a         = a_t;
    assign bus1.b         = b_t;
    assign bus1.acc_en    = acc_en_t;
    assign bus1.addend    = addend_t;
    assign bus1.out_ready = out_ready_t && (sel == 1);

    assign bus2.in_valid  = in_valid_t && (sel == 2);
    assign bus2.a         = a_t[3:0];
    assign bus2.b         = b_t[3:0];
    assign bus2.acc_en    = acc_en_t;
    assign bus2.addend    = addend_t[7:0];
    assign bus2.out_ready = out_ready_t && (sel == 2);

    seq_mult_acc #(.WIDTH(24), .EARLY_TERM(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    seq_mult_acc #(.WIDTH(24), .EARLY_TERM(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    seq_mult_acc #(.WIDTH(4),  .EARLY_TERM(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Route the selected instance's outputs to one observation point.
    always_comb begin
        obs_in_ready  = bus0.in_ready;
        obs_out_valid = bus0.out_valid;
        obs_product   = bus0.product;
        obs_ovf       = bus0.ovf;
        obs_busy      = bus0.busy;
        case (sel)
            1: begin
                obs_in_ready  = bus1.in_ready;
                obs_out_valid = bus1.out_valid;
                obs_product   = bus1.product;
                obs_ovf       = bus1.ovf;
                obs_busy      = bus1.busy;
            end
            2: begin
                obs_in_ready  = bus2.in_ready;
                obs_out_valid = bus2.out_valid;
                obs_product   = 48'(bus2.product);
                obs_ovf       = bus2.ovf;
                obs_busy      = bus2.busy;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (unit %0d): got 0x%0h, expected 0x%0h", tag, sel, got, exp);
        end
    endtask

    // Reference: full unsigned a*b (+addend), 2w+1 bits wide.
    function automatic logic [63:0] ref_total(input int w, input logic [23:0] a, input logic [23:0] b,
                                              input logic en, input logic [47:0] add);
        logic [63:0] op_mask;
        logic [63:0] sum_mask;
        op_mask  = (64'd1 << w) - 64'd1;
        sum_mask = (64'd1 << (2 * w)) - 64'd1;
        return (64'(a) & op_mask) * (64'(b) & op_mask) + (en ? (64'(add) & sum_mask) : 64'd0);
    endfunction

    // Reference latency: full width, or 1 + highest set multiplier bit.
    function automatic int ref_latency(input int w, input bit et, input logic [23:0] b);
        int h;
        h = -1;
        if (!et) return w;
        for (int i = 0; i < w; i++) begin
            if (b[i]) h = i;
        end
        return (h < 0) ? 1 : h + 1;
    endfunction

    task automatic launch(input int s, input logic [23:0] a, input logic [23:0] b,
                          input logic en, input logic [47:0] add);
        @(negedge clk);
        sel = s;
        #1;
        check("in_ready_idle", 64'(obs_in_ready), 64'd1);
        a_t        = a;
        b_t        = b;
        acc_en_t   = en;
        addend_t   = add;
        in_valid_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_t = 1'b0;
        // Scramble the operand bus: only the capture edge may matter.
        a_t        = 24'($urandom);
        b_t        = 24'($urandom);
        acc_en_t   = ~en;
        addend_t   = ~add;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!obs_out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op();
        out_ready_t = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_t = 1'b0;
        check("in_ready_after_hs", 64'(obs_in_ready), 64'd1);
        check("out_valid_after_hs", 64'(obs_out_valid), 64'd0);
    endtask

    task automatic do_op(input int s, input logic [23:0] a, input logic [23:0] b,
                         input logic en, input logic [47:0] add);
        int          w;
        int          lat;
        logic [63:0] total;
        w = (s == 2) ? 4 : 24;
        total = ref_total(w, a, b, en, add);
        launch(s, a, b, en, add);
        wait_result(lat);
        check("latency", 64'(lat), 64'(ref_latency(w, s == 1, b)));
        check("product", 64'(obs_product), total & ((64'd1 << (2 * w)) - 64'd1));
        check("ovf", 64'(obs_ovf), (total >> (2 * w)) & 64'd1);
        finish_op();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [23:0] ra;
        logic [23:0] rb;
        logic [47:0] radd;

        sel         = 0;
        in_valid_t  = 1'b0;
        acc_en_t    = 1'b0;
        out_ready_t = 1'b0;
        a_t         = '0;
        b_t         = '0;
        addend_t    = '0;

        // Reset state on every instance.
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_in_ready", 64'(obs_in_ready), 64'd1);
            check("rst_out_valid", 64'(obs_out_valid), 64'd0);
            check("rst_product", 64'(obs_product), 64'd0);
            check("rst_ovf", 64'(obs_ovf), 64'd0);
            check("rst_busy", 64'(obs_busy), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Corner operands, with and without accumulate overflow.
        do_op(0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'h0);
        do_op(0, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'hFFFFFFFFFFFF);
        do_op(1, 24'h800000, 24'h000001, 1'b0, 48'h0);
        do_op(1, 24'h800000, 24'h000000, 1'b0, 48'h0);
        do_op(1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'hFFFFFFFFFFFF);

        // Random operands on both 24-bit instances.
        for (int i = 0; i < 20; i++) begin
            ra   = 24'($urandom);
            rb   = 24'($urandom) >> $urandom_range(0, 24);
            radd = 48'({$urandom(), $urandom()});
            do_op(i % 2, ra, rb, 1'($urandom), radd);
        end

        // Backpressure: result held while operands are pulsed at a busy unit.
        launch(0, 24'd3, 24'd5, 1'b0, 48'h0);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'(ref_latency(24, 1'b0, 24'd5)));
        for (int k = 0; k < 5; k++) begin
            in_valid_t = (k % 2 == 0);
            a_t        = 24'($urandom);
            b_t        = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_product", 64'(obs_product), ref_total(24, 24'd3, 24'd5, 1'b0, 48'h0));
            check("bp_out_valid", 64'(obs_out_valid), 64'd1);
            check("bp_in_ready", 64'(obs_in_ready), 64'd0);
        end
        in_valid_t = 1'b0;
        finish_op();
        @(negedge clk);
        check("bp_not_accepted", 64'(obs_busy), 64'd0);

        // Asynchronous reset in the middle of a run.
        launch(0, 24'hABCDEF, 24'hFFFFFF, 1'b0, 48'h0);
        repeat (10) @(posedge clk);
        #2;
        check("mid_run_busy", 64'(obs_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(obs_out_valid), 64'd0);
        check("arst_product", 64'(obs_product), 64'd0);
        check("arst_busy", 64'(obs_busy), 64'd0);
        check("arst_in_ready", 64'(obs_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 24'd2, 24'd7, 1'b0, 48'h0);

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int en = 0; en < 2; en++) begin
                    for (int k = 0; k < 3; k++) begin
                        radd = (k == 0) ? 48'h0 : (k == 1) ? 48'hFF : 48'($urandom_range(0, 255));
                        do_op(2, 24'(a), 24'(b), 1'(en), radd);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
